output_port_bank: RTL and testbench

- Memory-mapped output port block for the 8-bit computer; the write-side counterpart of the 16 input ports (port_in_00..port_in_15).
- Sits on the CPU data-memory bus beside the input-port mux.
- Captures CPU stores to addresses BASE_ADDR..BASE_ADDR+15 into sixteen registered 8-bit output ports.
- Provides a registered readback path and a one-cycle update strobe per port for downstream peripherals (LEDs, displays).

---
 rtl/output_port_bank.sv | 93 +++++++++
 tb/tb_output_port_bank.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/output_port_bank.sv
// Sixteen memory-mapped 8-bit output ports on the CPU data bus, with registered readback,
// a per-port one-cycle update strobe and a registered address-hit flag.
module output_port_bank #(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  address,
    input  logic [7:0]  data_in,
    input  logic        write,
    output logic [7:0]  data_out,
    output logic [7:0]  port_out_00,
    output logic [7:0]  port_out_01,
    output logic [7:0]  port_out_02,
    output logic [7:0]  port_out_03,
    output logic [7:0]  port_out_04,
    output logic [7:0]  port_out_05,
    output logic [7:0]  port_out_06,
    output logic [7:0]  port_out_07,
    output logic [7:0]  port_out_08,
    output logic [7:0]  port_out_09,
    output logic [7:0]  port_out_10,
    output logic [7:0]  port_out_11,
    output logic [7:0]  port_out_12,
    output logic [7:0]  port_out_13,
    output logic [7:0]  port_out_14,
    output logic [7:0]  port_out_15,
    output logic [15:0] port_strobe,
    output logic        hit
);

    logic [15:0][7:0] port_q, port_d;
    logic [15:0]      strobe_q, strobe_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             hit_q;
    logic             in_range;
    logic [3:0]       idx;

    assign in_range = (address[7:4] == BASE_ADDR[7:4]);
    assign idx      = address[3:0];

    // A write cycle never forwards to readback; data_out returns 0 while storing.
    always_comb begin
        port_d     = port_q;
        strobe_d   = '0;
        data_out_d = 8'h00;
        if (in_range) begin
            if (write) begin
                port_d[idx]   = data_in;
                strobe_d[idx] = 1'b1;
            end else begin
                data_out_d = port_q[idx];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            port_q     <= {16{RESET_VAL}};
            strobe_q   <= '0;
            data_out_q <= 8'h00;
            hit_q      <= 1'b0;
        end else begin
            port_q     <= port_d;
            strobe_q   <= strobe_d;
            data_out_q <= data_out_d;
            hit_q      <= in_range;
        end
    end

    assign data_out    = data_out_q;
    assign port_strobe = strobe_q;
    assign hit         = hit_q;

    assign port_out_00 = port_q[0];
    assign port_out_01 = port_q[1];
    assign port_out_02 = port_q[2];
    assign port_out_03 = port_q[3];
    assign port_out_04 = port_q[4];
    assign port_out_05 = port_q[5];
    assign port_out_06 = port_q[6];
    assign port_out_07 = port_q[7];
    assign port_out_08 = port_q[8];
    assign port_out_09 = port_q[9];
    assign port_out_10 = port_q[10];
    assign port_out_11 = port_q[11];
    assign port_out_12 = port_q[12];
    assign port_out_13 = port_q[13];
    assign port_out_14 = port_q[14];
    assign port_out_15 = port_q[15];

endmodule

// File: tb/tb_output_port_bank.sv
// Bench for output_port_bank: directed vector table, reset corner cases, and random traffic
// checked against an array-based model of the sixteen ports.
module tb_output_port_bank;

    logic        clock;
    logic        reset;
    logic [7:0]  address;
    logic [7:0]  data_in;
    logic        write;
    logic [7:0]  data_out;
    logic [15:0] port_strobe;
    logic        hit;
    logic [7:0]  po [16];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_port [16];
    logic [15:0] e_strobe;
    logic [7:0]  e_dout;
    logic        e_hit;

    output_port_bank dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data_in     (data_in),
        .write       (write),
        .data_out    (data_out),
        .port_out_00 (po[0]),
        .port_out_01 (po[1]),
        .port_out_02 (po[2]),
        .port_out_03 (po[3]),
        .port_out_04 (po[4]),
        .port_out_05 (po[5]),
        .port_out_06 (po[6]),
        .port_out_07 (po[7]),
        .port_out_08 (po[8]),
        .port_out_09 (po[9]),
        .port_out_10 (po[10]),
        .port_out_11 (po[11]),
        .port_out_12 (po[12]),
        .port_out_13 (po[13]),
        .port_out_14 (po[14]),
        .port_out_15 (po[15]),
        .port_strobe (port_strobe),
        .hit         (hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        wr;
        logic [15:0] exp_strobe;
        logic [7:0]  exp_dout;
        logic        exp_hit;
        int          pidx;
        logic [7:0]  exp_port;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_port[i] = 8'h00;
        e_strobe = 16'h0000;
        e_dout   = 8'h00;
        e_hit    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " strobe"}, port_strobe, e_strobe);
        chk({tag, " data_out"}, {8'h00, data_out}, {8'h00, e_dout});
        chk({tag, " hit"}, {15'h0, hit}, {15'h0, e_hit});
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s port%0d", tag, i), {8'h00, po[i]}, {8'h00, m_port[i]});
    endtask

    // Drive one bus cycle between edges, advance the model, sample after the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] d, input logic w);
        bit          in_r;
        int          n;
        @(negedge clock);
        address = a;
        data_in = d;
        write   = w;
        in_r = (a >= 8'hE0) && (a <= 8'hEF);
        n    = int'(a) - 8'hE0;
        e_hit    = in_r;
        e_strobe = (in_r && w) ? (16'h0001 << n) : 16'h0000;
        e_dout   = (in_r && !w) ? m_port[n] : 8'h00;
        if (in_r && w) m_port[n] = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{8'hE5, 8'hA7, 1'b1, 16'h0020, 8'h00, 1'b1, 5,  8'hA7};
        vecs[1]  = '{8'hE0, 8'h11, 1'b1, 16'h0001, 8'h00, 1'b1, 0,  8'h11};
        vecs[2]  = '{8'hEF, 8'h22, 1'b1, 16'h8000, 8'h00, 1'b1, 15, 8'h22};
        vecs[3]  = '{8'hDF, 8'h99, 1'b1, 16'h0000, 8'h00, 1'b0, 15, 8'h22};
        vecs[4]  = '{8'hF0, 8'h99, 1'b1, 16'h0000, 8'h00, 1'b0, 0,  8'h11};
        vecs[5]  = '{8'hE7, 8'h01, 1'b1, 16'h0080, 8'h00, 1'b1, 7,  8'h01};
        vecs[6]  = '{8'hE7, 8'h02, 1'b1, 16'h0080, 8'h00, 1'b1, 7,  8'h02};
        vecs[7]  = '{8'hE8, 8'h03, 1'b1, 16'h0100, 8'h00, 1'b1, 8,  8'h03};
        vecs[8]  = '{8'hEA, 8'hC3, 1'b1, 16'h0400, 8'h00, 1'b1, 10, 8'hC3};
        vecs[9]  = '{8'hEA, 8'h00, 1'b0, 16'h0000, 8'hC3, 1'b1, 10, 8'hC3};
        vecs[10] = '{8'h10, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 7,  8'h02};
        vecs[11] = '{8'hE5, 8'h00, 1'b0, 16'h0000, 8'hA7, 1'b1, 5,  8'hA7};
        vecs[12] = '{8'hEF, 8'h00, 1'b0, 16'h0000, 8'h22, 1'b1, 8,  8'h03};

        // Reset held with a write pending on the bus
        reset   = 1'b0;
        write   = 1'b1;
        address = 8'hE3;
        data_in = 8'h5A;
        model_reset();
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            check_all("reset_hold");
        end
        write   = 1'b0;
        address = 8'h00;
        reset   = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].addr, vecs[i].data, vecs[i].wr);
            chk($sformatf("vec%0d strobe", i), port_strobe, vecs[i].exp_strobe);
            chk($sformatf("vec%0d data_out", i), {8'h00, data_out}, {8'h00, vecs[i].exp_dout});
            chk($sformatf("vec%0d hit", i), {15'h0, hit}, {15'h0, vecs[i].exp_hit});
            chk($sformatf("vec%0d port", i), {8'h00, po[vecs[i].pidx]},
                {8'h00, vecs[i].exp_port});
            check_all($sformatf("vec%0d model", i));
        end

        // Strobe must not persist into an idle cycle
        step(8'h00, 8'h00, 1'b0);
        check_all("idle");

        // Reset between edges during a write
        step(8'hE2, 8'h44, 1'b1);
        chk("pre_reset port2", {8'h00, po[2]}, 16'h0044);
        @(negedge clock);
        write   = 1'b1;
        address = 8'hE2;
        data_in = 8'h77;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clock);
        #1;
        check_all("reset_over_write");
        @(negedge clock);
        reset   = 1'b1;
        write   = 1'b0;
        address = 8'h00;
        step(8'h00, 8'h00, 1'b0);
        check_all("post_reset");
        step(8'hE2, 8'h00, 1'b0);
        check_all("post_reset_read");

        // Random traffic, biased into the port window
        for (int r = 0; r < 400; r++) begin
            logic [7:0] a;
            if ($urandom_range(0, 3) != 0) a = 8'hE0 | 8'($urandom_range(0, 15));
            else a = 8'($urandom);
            step(a, 8'($urandom), 1'($urandom_range(0, 1)));
            check_all($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
